rptr_empty: RTL
===============

# rptr_empty

Read-side pointer and empty-flag logic of the asynchronous FIFO, the counterpart of the write-pointer/full block. It runs entirely in the read clock domain and does four things: synchronizes the write-domain Gray pointer, owns the binary read counter and Gray read pointer, and produces registered empty, almost-empty and occupancy status. It also raises a sticky underflow error. The binary read address drives the read port of the dual-port storage; the Gray read pointer goes to the write domain's synchronizer.

## Interface
Parameters:
- ADDR_SIZE, 3, storage address width; FIFO depth = 2^ADDR_SIZE
- AE_THRESH, 1, almost-empty threshold in entries; legal range 0..2^ADDR_SIZE

Ports:
- rclk  in  1  read clock; the only clock in the block
- rrst_n  in  1  asynchronous active-low reset
- rpop  in  1  read request
- wptr  in  ADDR_SIZE+1  Gray write pointer, launched from the write domain, asynchronous to rclk
- ren  out  1  read accepted = rpop & ~rempty; combinational
- raddr  out  ADDR_SIZE  binary storage read address
- rptr  out  ADDR_SIZE+1  Gray read pointer, registered, sent to the write domain
- rempty  out  1  FIFO empty, registered
- ralmost_empty  out  1  occupancy <= AE_THRESH, registered
- rlevel  out  ADDR_SIZE+1  occupancy as seen by the read side, 0..2^ADDR_SIZE, registered
- rerr  out  1  sticky underflow flag

## Operation
- Synchronizer: wptr passes through two rclk flops, giving wq1 and then wq2. wq2 is the synchronized write pointer. No other logic samples wptr.
- Read counter:
  - rbin is ADDR_SIZE+1 bits, with the wrap bit kept explicitly.
  - rbin_next = rbin + ren, modulo 2^(ADDR_SIZE+1).
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
  - On each edge: rbin <= rbin_next and rptr <= rgray_next.
  - raddr = rbin[ADDR_SIZE-1:0].
- Empty: rempty <= (rgray_next == wq2), a full-width compare including the MSB.
- Level:
  - wbin = gray-to-binary(wq2), where wbin[i] = XOR of wq2[ADDR_SIZE:i].
  - rlevel <= wbin - rbin_next, modulo 2^(ADDR_SIZE+1).
- Almost-empty: ralmost_empty <= (wbin - rbin_next) <= AE_THRESH.
- Underflow: if rpop & rempty, then rerr <= 1. rerr clears only on reset.
- Rejected pops: a pop while empty is dropped. ren = 0, and rbin, raddr and rptr hold.
- Data: storage read data for raddr is valid in the cycle ren is high. Data registering is outside this block.
- Reset (rrst_n low): asynchronous, no clock edge required. Values while low:
  - wq1 = wq2 = 0, rbin = 0, raddr = 0, rptr = 0
  - rempty = 1, ralmost_empty = 1, rlevel = 0, rerr = 0
  - ren = 0, since rempty = 1

## Timing
- Reset release: rrst_n deasserts synchronously to rclk, handled externally. The first active edge is the first rclk rising edge with rrst_n high.
- Write visibility: a wptr change stable before edge N reaches wq2 at edge N+1. rempty, rlevel and ralmost_empty reflect it at edge N+2, so the latency is 3 edges counting edge N.
- Pop latency: a pop accepted at edge N updates raddr, rptr, rempty and rlevel at edge N, with zero extra latency.
- Back-to-back pops: one accepted pop per cycle while rempty = 0.
- Conservatism: rempty and rlevel are pessimistic only. The block may report empty or low occupancy late, but must never report data that is not yet written.
- Simultaneous pop and write arrival: both apply on the same edge. The level is the new wbin minus rbin_next.
- Wrap-around: rbin rolls from 2^(ADDR_SIZE+1)-1 to 0 and raddr rolls from 2^ADDR_SIZE-1 to 0. Neither disturbs empty or level.

## Test plan
All scenarios use ADDR_SIZE = 3 and AE_THRESH = 1.
- **Reset:** rrst_n = 0 with rpop = 1 and wptr = 0101 -> immediately rempty = 1, ralmost_empty = 1, rlevel = 0, raddr = 0, rptr = 0000, rerr = 0, ren = 0.
- **Basic read-out:** wptr = 0010 (3 entries) -> rempty = 0, rlevel = 3, ralmost_empty = 0 after 3 edges. Then 3 consecutive pops -> raddr 0, 1, 2; ren = 1 each cycle; after the third, rempty = 1, rlevel = 0, rptr = 0010.
- **Full depth and wrap:** wptr = 1100 (8 entries) -> rlevel = 8. 8 pops -> raddr 7 → 0, rptr = 1100, rempty = 1. Then wptr = 1010 (12) -> rlevel = 4; 4 pops -> raddr 0..3, rptr = 1010, rempty = 1.
- **Underflow:** rempty = 1, rpop = 1 for one cycle -> ren = 0, raddr and rptr unchanged, rerr = 1 next edge. rerr stays 1 after later valid reads, until reset.
- **Simultaneous events:** rlevel = 1, pop at the same edge wq2 advances by 1 -> rempty stays 0, rlevel = 1. Pop at rlevel = 2 -> ralmost_empty = 1 on that edge.
- **Reset mid-operation:** rlevel = 5, raddr = 3, assert rrst_n low between edges -> all outputs take reset values without a clock. After release with wptr = 0111 (5) held -> rlevel = 5, rempty = 0 after 3 edges, raddr = 0.

Source files
------------

// File: rtl/rptr_empty.sv
`default_nettype none
// ============================================================================
// Module  : rptr_empty
// Brief   : Read-domain side of an asynchronous FIFO. Synchronizes the Gray
//           write pointer, owns the read counter, and produces registered
//           empty, almost-empty, occupancy and sticky underflow status.
// Rev     : 1.0  initial release
// ============================================================================
module rptr_empty #(
  parameter int ADDR_SIZE = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rpop,
  input  logic [ADDR_SIZE:0]   wptr,
  output logic                 ren,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDR_SIZE:0]   rlevel,
  output logic                 rerr
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] c_ae_thresh = PW'(AE_THRESH);

  logic [ADDR_SIZE:0] wq1_q, wq1_d;
  logic [ADDR_SIZE:0] wq2_q, wq2_d;
  logic [ADDR_SIZE:0] rbin_q, rbin_d;
  logic [ADDR_SIZE:0] rptr_q, rptr_d;
  logic               rempty_q, rempty_d;
  logic               ralmost_empty_q, ralmost_empty_d;
  logic [ADDR_SIZE:0] rlevel_q, rlevel_d;
  logic               rerr_q, rerr_d;

  logic [ADDR_SIZE:0] w_wbin;
  logic [ADDR_SIZE:0] w_level;
  logic               w_ren;

  // Two-flop synchronizer; wq2 is the only view of the write pointer used below.
  always_comb begin
    wq1_d = wptr;
    wq2_d = wq1_q;
  end

  // Gray to binary: each bit is the XOR of itself and all higher bits.
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_wbin[i] = ^(wq2_q >> i);
    end
  end

  always_comb begin
    w_ren           = rpop & ~rempty_q;
    rbin_d          = rbin_q + {{ADDR_SIZE{1'b0}}, w_ren};
    rptr_d          = (rbin_d >> 1) ^ rbin_d;
    // Status uses the post-pop counter so an accepted pop is reflected on the same edge.
    w_level         = w_wbin - rbin_d;
    rempty_d        = (rptr_d == wq2_q);
    ralmost_empty_d = (w_level <= c_ae_thresh);
    rlevel_d        = w_level;
    rerr_d          = rerr_q | (rpop & rempty_q);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wq1_q           <= '0;
      wq2_q           <= '0;
      rbin_q          <= '0;
      rptr_q          <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rlevel_q        <= '0;
      rerr_q          <= 1'b0;
    end else begin
      wq1_q           <= wq1_d;
      wq2_q           <= wq2_d;
      rbin_q          <= rbin_d;
      rptr_q          <= rptr_d;
      rempty_q        <= rempty_d;
      ralmost_empty_q <= ralmost_empty_d;
      rlevel_q        <= rlevel_d;
      rerr_q          <= rerr_d;
    end
  end

  assign ren           = w_ren;
  assign raddr         = rbin_q[ADDR_SIZE-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel        = rlevel_q;
  assign rerr          = rerr_q;

endmodule
`default_nettype wire
